// File: rtl/sync_lock_ctrl_if.sv
// Signal bundle between the genlock controller and its environment:
// the raw CPS2 sync inputs plus the resync strobes, lock status and measurements.
interface sync_lock_ctrl_if;
   logic        HSYNC_in;
   logic        VSYNC_in;
   logic        resync_h;
   logic        resync_v;
   logic        locked;
   logic        pattern_sel;
   logic [1:0]  state;
   logic [11:0] hs_period;
   logic [10:0] lines_per_frame;

   modport master (
      output HSYNC_in, VSYNC_in,
      input  resync_h, resync_v, locked, pattern_sel, state, hs_period, lines_per_frame
   );

   modport slave (
      input  HSYNC_in, VSYNC_in,
      output resync_h, resync_v, locked, pattern_sel, state, hs_period, lines_per_frame
   );
endinterface

// File: rtl/sync_lock_ctrl.sv
// Genlock controller: measures incoming HSYNC/VSYNC timing, qualifies each frame,
// runs the lock FSM and issues resync strobes to the 640x480 timing generator.
module sync_lock_ctrl #(
   parameter int unsigned H_TOTAL       = 800,
   parameter int unsigned V_TOTAL       = 524,
   parameter int unsigned H_TOL         = 4,
   parameter int unsigned V_TOL         = 2,
   parameter int unsigned LOCK_FRAMES   = 3,
   parameter int unsigned UNLOCK_FRAMES = 4,
   parameter int unsigned TIMEOUT_CYC   = 838400
) (
   input  logic            clk25,
   input  logic            reset_n,
   sync_lock_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      FREERUN = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2,
      HOLD    = 2'd3
   } state_t;

   localparam logic [11:0] HCYC_MAX = 12'hFFF;
   localparam logic [10:0] LCNT_MAX = 11'h7FF;
   localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYC - 1);
   localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);
   localparam logic [3:0]  UNLOCK_N = 4'(UNLOCK_FRAMES);
   localparam logic [12:0] H_REF    = 13'(H_TOTAL);
   localparam logic [12:0] V_REF    = 13'(V_TOTAL);
   localparam logic [12:0] H_LIM    = 13'(H_TOL);
   localparam logic [12:0] V_LIM    = 13'(V_TOL);

   logic        hs_s1_q, hs_s2_q, hs_prev_q;
   logic        vs_s1_q, vs_s2_q, vs_prev_q;
   logic [11:0] hcyc_q, hcyc_d;
   logic [11:0] hs_period_q, hs_period_d;
   logic [10:0] lcnt_q, lcnt_d;
   logic [10:0] lpf_q, lpf_d;
   logic [19:0] vage_q, vage_d;
   state_t      state_q, state_d;
   logic [3:0]  gcnt_q, gcnt_d;
   logic [3:0]  bcnt_q, bcnt_d;
   logic        hpend_q, hpend_d;
   logic        resync_h_q, resync_h_d;
   logic        resync_v_q, resync_v_d;

   logic               hs_fall_s, vs_fall_s, tmo_s;
   logic               good_s, good_ev_s, bad_ev_s;
   logic signed [12:0] h_err_s, l_err_s;
   logic        [12:0] h_abs_s, l_abs_s;

   assign hs_fall_s = hs_prev_q & ~hs_s2_q;
   assign vs_fall_s = vs_prev_q & ~vs_s2_q;

   // Measurement counters, frame qualification and timeout detection.
   always_comb begin
      hcyc_d      = (hcyc_q == HCYC_MAX) ? HCYC_MAX : hcyc_q + 12'd1;
      hs_period_d = hs_period_q;
      lcnt_d      = lcnt_q;
      lpf_d       = lpf_q;
      if (hs_fall_s) begin
         hcyc_d      = 12'd1;
         hs_period_d = hcyc_q;
      end else begin
         hs_period_d = hs_period_q;
      end
      // A coincident hs_fall is deliberately dropped from the line count.
      if (vs_fall_s) begin
         lpf_d  = lcnt_q;
         lcnt_d = 11'd0;
      end else if (hs_fall_s) begin
         lcnt_d = (lcnt_q == LCNT_MAX) ? LCNT_MAX : lcnt_q + 11'd1;
      end else begin
         lcnt_d = lcnt_q;
      end

      h_err_s = $signed({1'b0, hs_period_q}) - $signed(H_REF);
      l_err_s = $signed({2'b00, lcnt_q}) - $signed(V_REF);
      h_abs_s = h_err_s[12] ? 13'(-h_err_s) : 13'(h_err_s);
      l_abs_s = l_err_s[12] ? 13'(-l_err_s) : 13'(l_err_s);
      good_s  = (h_abs_s <= H_LIM) && (l_abs_s <= V_LIM);

      tmo_s  = ~vs_fall_s & (vage_q == TMO_LAST);
      vage_d = (vs_fall_s | tmo_s) ? 20'd0 : vage_q + 20'd1;

      good_ev_s = vs_fall_s & good_s;
      bad_ev_s  = (vs_fall_s & ~good_s) | tmo_s;
   end

   // Lock FSM next-state and resync strobe generation.
   always_comb begin
      state_d = state_q;
      gcnt_d  = gcnt_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         FREERUN: begin
            if (good_ev_s) begin
               state_d = (LOCK_N == 4'd1) ? LOCKED : ACQUIRE;
               gcnt_d  = (LOCK_N == 4'd1) ? 4'd0 : 4'd1;
            end else begin
               gcnt_d = 4'd0;
            end
         end
         ACQUIRE: begin
            if (good_ev_s) begin
               state_d = (gcnt_q + 4'd1 == LOCK_N) ? LOCKED : ACQUIRE;
               gcnt_d  = (gcnt_q + 4'd1 == LOCK_N) ? 4'd0 : gcnt_q + 4'd1;
            end else if (bad_ev_s) begin
               state_d = FREERUN;
               gcnt_d  = 4'd0;
            end else begin
               gcnt_d = gcnt_q;
            end
         end
         LOCKED: begin
            if (bad_ev_s) begin
               state_d = (UNLOCK_N == 4'd1) ? FREERUN : HOLD;
               bcnt_d  = (UNLOCK_N == 4'd1) ? 4'd0 : 4'd1;
            end else begin
               bcnt_d = 4'd0;
            end
         end
         HOLD: begin
            if (good_ev_s) begin
               state_d = LOCKED;
               bcnt_d  = 4'd0;
            end else if (bad_ev_s) begin
               state_d = (bcnt_q + 4'd1 == UNLOCK_N) ? FREERUN : HOLD;
               bcnt_d  = (bcnt_q + 4'd1 == UNLOCK_N) ? 4'd0 : bcnt_q + 4'd1;
            end else begin
               bcnt_d = bcnt_q;
            end
         end
         default: begin
            state_d = FREERUN;
            gcnt_d  = 4'd0;
            bcnt_d  = 4'd0;
         end
      endcase

      resync_v_d = good_ev_s & ((state_q == LOCKED) | (state_q == HOLD));
      resync_h_d = hpend_q & hs_fall_s & ~resync_v_d;
      if ((state_d == FREERUN) || (state_d == ACQUIRE)) begin
         hpend_d = 1'b0;
      end else if (resync_v_d) begin
         hpend_d = 1'b1;
      end else if (resync_h_d) begin
         hpend_d = 1'b0;
      end else begin
         hpend_d = hpend_q;
      end
   end

   // All state: synchronizers, counters, FSM and registered strobes.
   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         hs_s1_q     <= 1'b1;
         hs_s2_q     <= 1'b1;
         hs_prev_q   <= 1'b1;
         vs_s1_q     <= 1'b1;
         vs_s2_q     <= 1'b1;
         vs_prev_q   <= 1'b1;
         hcyc_q      <= 12'd0;
         hs_period_q <= 12'd0;
         lcnt_q      <= 11'd0;
         lpf_q       <= 11'd0;
         vage_q      <= 20'd0;
         state_q     <= FREERUN;
         gcnt_q      <= 4'd0;
         bcnt_q      <= 4'd0;
         hpend_q     <= 1'b0;
         resync_h_q  <= 1'b0;
         resync_v_q  <= 1'b0;
      end else begin
         hs_s1_q     <= bus.HSYNC_in;
         hs_s2_q     <= hs_s1_q;
         hs_prev_q   <= hs_s2_q;
         vs_s1_q     <= bus.VSYNC_in;
         vs_s2_q     <= vs_s1_q;
         vs_prev_q   <= vs_s2_q;
         hcyc_q      <= hcyc_d;
         hs_period_q <= hs_period_d;
         lcnt_q      <= lcnt_d;
         lpf_q       <= lpf_d;
         vage_q      <= vage_d;
         state_q     <= state_d;
         gcnt_q      <= gcnt_d;
         bcnt_q      <= bcnt_d;
         hpend_q     <= hpend_d;
         resync_h_q  <= resync_h_d;
         resync_v_q  <= resync_v_d;
      end
   end

   assign bus.resync_h        = resync_h_q;
   assign bus.resync_v        = resync_v_q;
   assign bus.state           = state_q;
   assign bus.locked          = state_q[1];
   assign bus.pattern_sel     = ~state_q[1];
   assign bus.hs_period       = hs_period_q;
   assign bus.lines_per_frame = lpf_q;

endmodule
